// File: rtl/miriscv_mem_arbiter.sv
// Shares one single-port RAM between the instruction-fetch and load/store ports.
// Only one access is in flight; its response is routed back to the issuing port.
module miriscv_mem_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned RAM_LATENCY = 1,
  parameter int unsigned FIXED_PRIO  = 0
) (
  input  logic                clk_i,
  input  logic                rst_n_i,

  input  logic                instr_req_i,
  input  logic [ADDR_W-1:0]   instr_addr_i,
  output logic                instr_gnt_o,
  output logic                instr_rvalid_o,
  output logic [DATA_W-1:0]   instr_rdata_o,

  input  logic                data_req_i,
  input  logic                data_we_i,
  input  logic [DATA_W/8-1:0] data_be_i,
  input  logic [ADDR_W-1:0]   data_addr_i,
  input  logic [DATA_W-1:0]   data_wdata_i,
  output logic                data_gnt_o,
  output logic                data_rvalid_o,
  output logic [DATA_W-1:0]   data_rdata_o,

  output logic                ram_req_o,
  output logic                ram_we_o,
  output logic [DATA_W/8-1:0] ram_be_o,
  output logic [ADDR_W-1:0]   ram_addr_o,
  output logic [DATA_W-1:0]   ram_wdata_o,
  input  logic [DATA_W-1:0]   ram_rdata_i,

  output logic                busy_o
);

  localparam int unsigned CNT_W     = 3;
  localparam int unsigned LAT_CLAMP = (RAM_LATENCY < 1) ? 1 :
                                      (RAM_LATENCY > 7) ? 7 : RAM_LATENCY;
  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(LAT_CLAMP);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_e;

  typedef enum logic {
    PORT_INSTR,
    PORT_DATA
  } port_e;

  state_e           state_q, state_d;
  port_e            owner_q, owner_d;
  port_e            last_q, last_d;
  port_e            winner;
  logic [CNT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic             any_req;
  logic             conflict;
  logic             resp_fire;

  // Round-robin hands a conflict to whichever port did not win the last grant.
  always_comb begin
    any_req  = instr_req_i | data_req_i;
    conflict = instr_req_i & data_req_i;
    if (conflict) begin
      if (FIXED_PRIO != 0) begin
        winner = PORT_DATA;
      end else begin
        winner = (last_q == PORT_DATA) ? PORT_INSTR : PORT_DATA;
      end
    end else begin
      winner = data_req_i ? PORT_DATA : PORT_INSTR;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    lat_cnt_d   = lat_cnt_q;
    instr_gnt_o = 1'b0;
    data_gnt_o  = 1'b0;
    ram_req_o   = 1'b0;
    ram_we_o    = 1'b0;
    ram_be_o    = '0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    resp_fire   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (any_req && rst_n_i) begin
          state_d   = ST_WAIT;
          owner_d   = winner;
          last_d    = winner;
          lat_cnt_d = LAT_INIT;
          ram_req_o = 1'b1;
          if (winner == PORT_DATA) begin
            data_gnt_o  = 1'b1;
            ram_we_o    = data_we_i;
            ram_be_o    = data_we_i ? data_be_i : '1;
            ram_addr_o  = data_addr_i;
            ram_wdata_o = data_wdata_i;
          end else begin
            instr_gnt_o = 1'b1;
            ram_be_o    = '1;
            ram_addr_o  = instr_addr_i;
          end
        end
      end

      ST_WAIT: begin
        lat_cnt_d = lat_cnt_q - CNT_W'(1);
        if (lat_cnt_q == CNT_W'(1)) begin
          state_d   = ST_IDLE;
          // An access interrupted by reset never reports a response.
          resp_fire = rst_n_i;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    instr_rvalid_o = resp_fire && (owner_q == PORT_INSTR);
    data_rvalid_o  = resp_fire && (owner_q == PORT_DATA);
    instr_rdata_o  = instr_rvalid_o ? ram_rdata_i : '0;
    data_rdata_o   = data_rvalid_o ? ram_rdata_i : '0;
    busy_o         = (state_q != ST_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      owner_q   <= PORT_INSTR;
      last_q    <= PORT_DATA;
      lat_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      lat_cnt_q <= lat_cnt_d;
    end
  end

endmodule

// File: tb/tb_miriscv_mem_arbiter.sv
// Bench for miriscv_mem_arbiter: three instances (RR/L1, fixed-prio/L1, RR/L3),
// each with its own RAM model; directed tables, sequences and a random phase.
module tb_miriscv_mem_arbiter;

  localparam int N = 3;

  logic        clk;
  logic        rst_n        [N];
  logic        instr_req    [N];
  logic [31:0] instr_addr   [N];
  logic        instr_gnt    [N];
  logic        instr_rvalid [N];
  logic [31:0] instr_rdata  [N];
  logic        data_req     [N];
  logic        data_we      [N];
  logic [3:0]  data_be      [N];
  logic [31:0] data_addr    [N];
  logic [31:0] data_wdata   [N];
  logic        data_gnt     [N];
  logic        data_rvalid  [N];
  logic [31:0] data_rdata   [N];
  logic        ram_req      [N];
  logic        ram_we       [N];
  logic [3:0]  ram_be       [N];
  logic [31:0] ram_addr     [N];
  logic [31:0] ram_wdata    [N];
  logic [31:0] ram_rdata    [N];
  logic        busy         [N];

  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(input int k);
    return (k == 2) ? 3 : 1;
  endfunction

  function automatic bit fp_of(input int k);
    return (k == 1);
  endfunction

  function automatic logic [31:0] init_word(input int i);
    if (i == 2) return 32'h1122_3344;
    if (i == 4) return 32'h0010_0093;
    return 32'hC0DE_0000 ^ (32'(i) * 32'h0103_0507);
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int unsigned LAT = (g == 2) ? 3 : 1;
    localparam int unsigned FP  = (g == 1) ? 1 : 0;

    miriscv_mem_arbiter #(
      .ADDR_W     (32),
      .DATA_W     (32),
      .RAM_LATENCY(LAT),
      .FIXED_PRIO (FP)
    ) u_dut (
      .clk_i         (clk),
      .rst_n_i       (rst_n[g]),
      .instr_req_i   (instr_req[g]),
      .instr_addr_i  (instr_addr[g]),
      .instr_gnt_o   (instr_gnt[g]),
      .instr_rvalid_o(instr_rvalid[g]),
      .instr_rdata_o (instr_rdata[g]),
      .data_req_i    (data_req[g]),
      .data_we_i     (data_we[g]),
      .data_be_i     (data_be[g]),
      .data_addr_i   (data_addr[g]),
      .data_wdata_i  (data_wdata[g]),
      .data_gnt_o    (data_gnt[g]),
      .data_rvalid_o (data_rvalid[g]),
      .data_rdata_o  (data_rdata[g]),
      .ram_req_o     (ram_req[g]),
      .ram_we_o      (ram_we[g]),
      .ram_be_o      (ram_be[g]),
      .ram_addr_o    (ram_addr[g]),
      .ram_wdata_o   (ram_wdata[g]),
      .ram_rdata_i   (ram_rdata[g]),
      .busy_o        (busy[g])
    );

    // RAM: 64 words, read data valid only in the cycle LAT after the request.
    logic [31:0] mem [64];
    logic        rd_pend;
    int          rd_rem;
    logic [31:0] rd_val;

    always @(posedge clk) begin
      if (!rst_n[g]) begin
        for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
        rd_pend <= 1'b0;
        rd_rem  <= 0;
        rd_val  <= '0;
      end else begin
        if (rd_pend) begin
          if (rd_rem == 0) rd_pend <= 1'b0;
          else             rd_rem  <= rd_rem - 1;
        end
        if (ram_req[g]) begin
          if (ram_we[g]) begin
            for (int b = 0; b < 4; b++)
              if (ram_be[g][b]) mem[ram_addr[g][7:2]][8*b +: 8] <= ram_wdata[g][8*b +: 8];
          end else begin
            rd_pend <= 1'b1;
            rd_rem  <= int'(LAT) - 1;
            rd_val  <= mem[ram_addr[g][7:2]];
          end
        end
      end
    end

    assign ram_rdata[g] = (rd_pend && rd_rem == 0) ? rd_val : 32'hDEAD_BEEF;
  end

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d t=%0t actual=0x%08h required=0x%08h", name, k, $time, act, exp);
    end
  endtask

  task automatic idle_inputs(input int k);
    instr_req[k]  = 1'b0;
    instr_addr[k] = '0;
    data_req[k]   = 1'b0;
    data_we[k]    = 1'b0;
    data_be[k]    = '0;
    data_addr[k]  = '0;
    data_wdata[k] = '0;
  endtask

  task automatic drive(input int k, input logic ireq, input logic [31:0] iaddr,
                       input logic dreq, input logic dwe, input logic [3:0] dbe,
                       input logic [31:0] daddr, input logic [31:0] dwdata);
    instr_req[k]  = ireq;
    instr_addr[k] = iaddr;
    data_req[k]   = dreq;
    data_we[k]    = dwe;
    data_be[k]    = dbe;
    data_addr[k]  = daddr;
    data_wdata[k] = dwdata;
  endtask

  task automatic reset_all();
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      rst_n[k] = 1'b0;
      idle_inputs(k);
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < N; k++) rst_n[k] = 1'b1;
  endtask

  typedef struct {
    logic        ireq, dreq, dwe;
    logic [3:0]  dbe;
    logic [31:0] iaddr, daddr, dwdata;
    logic        egi, egd, ewe;
    logic [3:0]  ebe;
    logic [31:0] eaddr, ewdata;
  } vec_t;

  task automatic run_table();
    vec_t tbl [9];
    tbl[0] = '{0, 0, 0, 4'h0, 32'h100, 32'h200, 32'h0,         0, 0, 0, 4'h0, 32'h0,   32'h0};
    tbl[1] = '{1, 1, 0, 4'h3, 32'h104, 32'h208, 32'h0,         1, 0, 0, 4'hF, 32'h104, 32'h0};
    tbl[2] = '{1, 1, 1, 4'h5, 32'h10C, 32'h2A0, 32'h5555_AAAA, 0, 1, 1, 4'h5, 32'h2A0, 32'h5555_AAAA};
    tbl[3] = '{0, 1, 1, 4'h2, 32'h110, 32'h2A4, 32'h0123_4567, 0, 1, 1, 4'h2, 32'h2A4, 32'h0123_4567};
    tbl[4] = '{1, 1, 0, 4'hF, 32'h114, 32'h2A8, 32'h0,         1, 0, 0, 4'hF, 32'h114, 32'h0};
    tbl[5] = '{1, 0, 0, 4'h0, 32'h118, 32'h2AC, 32'h0,         1, 0, 0, 4'hF, 32'h118, 32'h0};
    tbl[6] = '{1, 1, 1, 4'h8, 32'h11C, 32'h2B0, 32'hCAFE_F00D, 0, 1, 1, 4'h8, 32'h2B0, 32'hCAFE_F00D};
    tbl[7] = '{1, 0, 1, 4'h0, 32'h120, 32'h2C0, 32'hFFFF_FFFF, 1, 0, 0, 4'hF, 32'h120, 32'h0};
    tbl[8] = '{1, 1, 1, 4'h1, 32'h124, 32'h2C4, 32'h0BAD_BEEF, 0, 1, 1, 4'h1, 32'h2C4, 32'h0BAD_BEEF};
    for (int v = 0; v < 9; v++) begin
      @(negedge clk);
      drive(0, tbl[v].ireq, tbl[v].iaddr, tbl[v].dreq, tbl[v].dwe, tbl[v].dbe,
            tbl[v].daddr, tbl[v].dwdata);
      #1;
      chk("tbl_instr_gnt", 0, 32'(instr_gnt[0]), 32'(tbl[v].egi));
      chk("tbl_data_gnt",  0, 32'(data_gnt[0]),  32'(tbl[v].egd));
      chk("tbl_ram_req",   0, 32'(ram_req[0]),   32'(tbl[v].egi | tbl[v].egd));
      if (tbl[v].egi || tbl[v].egd) begin
        chk("tbl_ram_we",   0, 32'(ram_we[0]), 32'(tbl[v].ewe));
        chk("tbl_ram_be",   0, 32'(ram_be[0]), 32'(tbl[v].ebe));
        chk("tbl_ram_addr", 0, ram_addr[0],    tbl[v].eaddr);
        if (tbl[v].ewe) chk("tbl_ram_wdata", 0, ram_wdata[0], tbl[v].ewdata);
      end
      @(negedge clk);
      idle_inputs(0);
      #1;
      chk("tbl_instr_rvalid", 0, 32'(instr_rvalid[0]), 32'(tbl[v].egi));
      chk("tbl_data_rvalid",  0, 32'(data_rvalid[0]),  32'(tbl[v].egd));
      chk("tbl_wait_ram_req", 0, 32'(ram_req[0]),      32'd0);
    end
  endtask

  task automatic seq_lone_fetch();
    @(negedge clk);
    drive(0, 1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    chk("lf_instr_gnt", 0, 32'(instr_gnt[0]), 32'd1);
    chk("lf_data_gnt",  0, 32'(data_gnt[0]),  32'd0);
    chk("lf_ram_req",   0, 32'(ram_req[0]),   32'd1);
    chk("lf_ram_we",    0, 32'(ram_we[0]),    32'd0);
    chk("lf_ram_be",    0, 32'(ram_be[0]),    32'hF);
    chk("lf_ram_addr",  0, ram_addr[0],       32'h10);
    chk("lf_busy_T",    0, 32'(busy[0]),      32'd0);
    @(negedge clk);
    idle_inputs(0);
    #1;
    chk("lf_instr_rvalid", 0, 32'(instr_rvalid[0]), 32'd1);
    chk("lf_instr_rdata",  0, instr_rdata[0],       32'h0010_0093);
    chk("lf_data_rvalid",  0, 32'(data_rvalid[0]),  32'd0);
    chk("lf_data_rdata",   0, data_rdata[0],        32'd0);
    chk("lf_busy_T1",      0, 32'(busy[0]),         32'd1);
    chk("lf_ram_req_T1",   0, 32'(ram_req[0]),      32'd0);
    @(negedge clk);
    #1;
    chk("lf_rvalid_T2", 0, 32'(instr_rvalid[0]), 32'd0);
    chk("lf_busy_T2",   0, 32'(busy[0]),         32'd0);
  endtask

  task automatic seq_conflict(input int k);
    logic prev_req;
    bit   gnt_now, i_win, prev_i_win;
    prev_req = 1'b0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      drive(k, 1'b1, 32'h20, 1'b1, 1'b0, 4'hF, 32'h24, 32'h0);
      #1;
      gnt_now    = (j % 2 == 0);
      i_win      = !fp_of(k) && ((j / 2) % 2 == 0);
      prev_i_win = !fp_of(k) && (((j - 1) / 2) % 2 == 0);
      chk("cf_instr_gnt", k, 32'(instr_gnt[k]), 32'(gnt_now && i_win));
      chk("cf_data_gnt",  k, 32'(data_gnt[k]),  32'(gnt_now && !i_win));
      chk("cf_ram_req",   k, 32'(ram_req[k]),   32'(gnt_now));
      chk("cf_ram_req_b2b", k, 32'(prev_req && ram_req[k]), 32'd0);
      chk("cf_instr_rvalid", k, 32'(instr_rvalid[k]), 32'(!gnt_now && prev_i_win));
      chk("cf_data_rvalid",  k, 32'(data_rvalid[k]),  32'(!gnt_now && !prev_i_win));
      if (!gnt_now && prev_i_win)  chk("cf_instr_rdata", k, instr_rdata[k], init_word(8));
      if (!gnt_now && !prev_i_win) chk("cf_data_rdata",  k, data_rdata[k],  init_word(9));
      prev_req = ram_req[k];
    end
    @(negedge clk);
    idle_inputs(k);
    repeat (2) @(negedge clk);
  endtask

  task automatic seq_store();
    @(negedge clk);
    drive(0, 1'b0, 32'h0, 1'b1, 1'b1, 4'b0010, 32'h8, 32'hAABB_CCDD);
    #1;
    chk("st_data_gnt",  0, 32'(data_gnt[0]),  32'd1);
    chk("st_instr_gnt", 0, 32'(instr_gnt[0]), 32'd0);
    chk("st_ram_we",    0, 32'(ram_we[0]),    32'd1);
    chk("st_ram_be",    0, 32'(ram_be[0]),    32'h2);
    chk("st_ram_addr",  0, ram_addr[0],       32'h8);
    chk("st_ram_wdata", 0, ram_wdata[0],      32'hAABB_CCDD);
    @(negedge clk);
    idle_inputs(0);
    #1;
    chk("st_data_rvalid",  0, 32'(data_rvalid[0]),  32'd1);
    chk("st_instr_rvalid", 0, 32'(instr_rvalid[0]), 32'd0);
    @(negedge clk);
    drive(0, 1'b1, 32'h8, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    chk("st_fetch_gnt", 0, 32'(instr_gnt[0]), 32'd1);
    @(negedge clk);
    idle_inputs(0);
    #1;
    chk("st_fetch_rvalid", 0, 32'(instr_rvalid[0]), 32'd1);
    chk("st_fetch_rdata",  0, instr_rdata[0],       32'h1122_CC44);
  endtask

  task automatic seq_abort(input bit fetch);
    @(negedge clk);
    if (fetch) drive(2, 1'b1, 32'h30, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    else       drive(2, 1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h30, 32'h0);
    #1;
    chk("ab_gnt", 2, 32'(fetch ? instr_gnt[2] : data_gnt[2]), 32'd1);
    @(negedge clk);
    idle_inputs(2);
    rst_n[2] = 1'b0;
    #1;
    chk("ab_rvalid_T1", 2, 32'(instr_rvalid[2] | data_rvalid[2]), 32'd0);
    @(negedge clk);
    rst_n[2] = 1'b1;
    #1;
    chk("ab_busy_T2",   2, 32'(busy[2]), 32'd0);
    chk("ab_rvalid_T2", 2, 32'(instr_rvalid[2] | data_rvalid[2]), 32'd0);
    @(negedge clk);
    #1;
    chk("ab_rvalid_T3", 2, 32'(instr_rvalid[2] | data_rvalid[2]), 32'd0);
    @(negedge clk);
    drive(2, 1'b1, 32'h34, 1'b1, 1'b0, 4'hF, 32'h38, 32'h0);
    #1;
    chk("ab_first_conflict_instr", 2, 32'(instr_gnt[2]), 32'd1);
    chk("ab_first_conflict_data",  2, 32'(data_gnt[2]),  32'd0);
    @(negedge clk);
    idle_inputs(2);
    repeat (4) @(negedge clk);
  endtask

  // Reference: each port is a requester with at most one pending access; the RAM is
  // free again L+1 cycles after a grant and the reply is due exactly L cycles after it.
  task automatic random_phase(input int ncycles);
    bit          ip [N], dp [N], last_d [N];
    logic [31:0] ia [N], da [N], dwd [N];
    logic        dwe [N];
    logic [3:0]  dbe [N];
    int          next_free [N], gcyc [N];
    logic [31:0] mm [N][64];
    bit          rsp_v [N], rsp_d [N], rsp_st [N];
    int          rsp_due [N];
    logic [31:0] rsp_data [N];
    bit          gi, gd, rv, can;
    int          L;
    for (int k = 0; k < N; k++) begin
      ip[k] = 0; dp[k] = 0; last_d[k] = 1; next_free[k] = 0; gcyc[k] = -10;
      rsp_v[k] = 0; rsp_d[k] = 0; rsp_st[k] = 0; rsp_due[k] = 0; rsp_data[k] = '0;
      ia[k] = '0; da[k] = '0; dwd[k] = '0; dwe[k] = 0; dbe[k] = '0;
      for (int i = 0; i < 64; i++) mm[k][i] = init_word(i);
    end
    for (int c = 0; c < ncycles; c++) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        if (!ip[k]) begin
          if ($urandom_range(0, 99) < 55) begin
            ip[k] = 1;
            ia[k] = $urandom & 32'hFFFF_FFFC;
          end
        end else if ($urandom_range(0, 99) < 8) begin
          ip[k] = 0;
        end
        if (!dp[k]) begin
          if ($urandom_range(0, 99) < 55) begin
            dp[k]  = 1;
            dwe[k] = 1'($urandom_range(0, 1));
            dbe[k] = 4'($urandom_range(1, 15));
            da[k]  = $urandom & 32'hFFFF_FFFC;
            dwd[k] = $urandom;
          end
        end else if ($urandom_range(0, 99) < 8) begin
          dp[k] = 0;
        end
        drive(k, ip[k], ip[k] ? ia[k] : $urandom,
              dp[k], dp[k] ? dwe[k] : 1'($urandom_range(0, 1)),
              dp[k] ? dbe[k] : 4'($urandom_range(0, 15)),
              dp[k] ? da[k] : $urandom, dp[k] ? dwd[k] : $urandom);
      end
      #1;
      for (int k = 0; k < N; k++) begin
        L   = lat_of(k);
        can = (c >= next_free[k]);
        gi  = 0;
        gd  = 0;
        if (can && (ip[k] || dp[k])) begin
          if (ip[k] && dp[k]) gd = fp_of(k) ? 1'b1 : !last_d[k];
          else                gd = dp[k];
          gi = !gd;
        end
        chk("rnd_instr_gnt", k, 32'(instr_gnt[k]), 32'(gi));
        chk("rnd_data_gnt",  k, 32'(data_gnt[k]),  32'(gd));
        chk("rnd_ram_req",   k, 32'(ram_req[k]),   32'(gi | gd));
        if (gi) begin
          chk("rnd_ram_we_i",   k, 32'(ram_we[k]), 32'd0);
          chk("rnd_ram_be_i",   k, 32'(ram_be[k]), 32'hF);
          chk("rnd_ram_addr_i", k, ram_addr[k],    ia[k]);
        end
        if (gd) begin
          chk("rnd_ram_we_d",   k, 32'(ram_we[k]), 32'(dwe[k]));
          chk("rnd_ram_addr_d", k, ram_addr[k],    da[k]);
          if (dwe[k]) begin
            chk("rnd_ram_be_d",    k, 32'(ram_be[k]), 32'(dbe[k]));
            chk("rnd_ram_wdata_d", k, ram_wdata[k],   dwd[k]);
          end
        end
        rv = rsp_v[k] && (rsp_due[k] == c);
        chk("rnd_instr_rvalid", k, 32'(instr_rvalid[k]), 32'(rv && !rsp_d[k]));
        chk("rnd_data_rvalid",  k, 32'(data_rvalid[k]),  32'(rv && rsp_d[k]));
        if (rv && !rsp_st[k]) begin
          if (rsp_d[k]) chk("rnd_data_rdata",  k, data_rdata[k],  rsp_data[k]);
          else          chk("rnd_instr_rdata", k, instr_rdata[k], rsp_data[k]);
        end
        chk("rnd_busy", k, 32'(busy[k]), 32'((c > gcyc[k]) && (c < next_free[k])));
        if (rv) rsp_v[k] = 0;
        if (gi || gd) begin
          gcyc[k]      = c;
          next_free[k] = c + L + 1;
          last_d[k]    = gd;
          rsp_v[k]     = 1;
          rsp_due[k]   = c + L;
          rsp_d[k]     = gd;
          rsp_st[k]    = gd && dwe[k];
          if (gi) begin
            rsp_data[k] = mm[k][ia[k][7:2]];
            ip[k] = 0;
          end else begin
            rsp_data[k] = mm[k][da[k][7:2]];
            if (dwe[k])
              for (int b = 0; b < 4; b++)
                if (dbe[k][b]) mm[k][da[k][7:2]][8*b +: 8] = dwd[k][8*b +: 8];
            dp[k] = 0;
          end
        end
      end
    end
    @(negedge clk);
    for (int k = 0; k < N; k++) idle_inputs(k);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t actual=timeout required=finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < N; k++) begin
      rst_n[k] = 1'b0;
      idle_inputs(k);
    end
    repeat (3) @(negedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      chk("rst_instr_gnt",    k, 32'(instr_gnt[k]),    32'd0);
      chk("rst_data_gnt",     k, 32'(data_gnt[k]),     32'd0);
      chk("rst_instr_rvalid", k, 32'(instr_rvalid[k]), 32'd0);
      chk("rst_data_rvalid",  k, 32'(data_rvalid[k]),  32'd0);
      chk("rst_ram_req",      k, 32'(ram_req[k]),      32'd0);
      chk("rst_ram_we",       k, 32'(ram_we[k]),       32'd0);
      chk("rst_ram_be",       k, 32'(ram_be[k]),       32'd0);
      chk("rst_ram_addr",     k, ram_addr[k],          32'd0);
      chk("rst_ram_wdata",    k, ram_wdata[k],         32'd0);
      chk("rst_instr_rdata",  k, instr_rdata[k],       32'd0);
      chk("rst_data_rdata",   k, data_rdata[k],        32'd0);
      chk("rst_busy",         k, 32'(busy[k]),         32'd0);
    end
    @(negedge clk);
    for (int k = 0; k < N; k++) rst_n[k] = 1'b1;

    run_table();
    reset_all();
    seq_lone_fetch();
    reset_all();
    seq_conflict(0);
    reset_all();
    seq_conflict(1);
    reset_all();
    seq_store();
    reset_all();
    seq_abort(1'b0);
    seq_abort(1'b1);
    reset_all();
    random_phase(400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
